// File: rtl/alu_issue_decoder_if.sv
// Handshake and data bundle between the issue decoder, its upstream feeder and the ALU.
interface alu_issue_decoder_if #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned SEL_SIZE   = 5,
  parameter int unsigned SHIFT_SIZE = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic [XLEN-1:0]       pc;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  alu_enable;
  logic [SEL_SIZE-1:0]   alu_sel;
  logic [SHIFT_SIZE-1:0] alu_shift_amt;
  logic [XLEN-1:0]       alu_data_a;
  logic [XLEN-1:0]       alu_data_b;
  logic [4:0]            rd_addr;
  logic                  rd_write;
  logic                  illegal;

  // Feeder / execute side.
  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, alu_enable, alu_sel, alu_shift_amt,
           alu_data_a, alu_data_b, rd_addr, rd_write, illegal
  );

  // Decoder side.
  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, alu_enable, alu_sel, alu_shift_amt,
           alu_data_a, alu_data_b, rd_addr, rd_write, illegal
  );
endinterface

// File: rtl/alu_issue_decoder.sv
// Registered RV64I integer-compute decode stage with a one-entry valid/ready output register.
module alu_issue_decoder #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned SEL_SIZE   = 5,
  parameter int unsigned SHIFT_SIZE = 6
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  alu_issue_decoder_if.slave bus
);
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;

  localparam logic [4:0] SelAdd   = 5'd0;
  localparam logic [4:0] SelSub   = 5'd1;
  localparam logic [4:0] SelSlt   = 5'd2;
  localparam logic [4:0] SelSltu  = 5'd3;
  localparam logic [4:0] SelAnd   = 5'd4;
  localparam logic [4:0] SelOr    = 5'd5;
  localparam logic [4:0] SelXor   = 5'd6;
  localparam logic [4:0] SelSll   = 5'd7;
  localparam logic [4:0] SelSrl   = 5'd8;
  localparam logic [4:0] SelSra   = 5'd9;
  localparam logic [4:0] SelLui   = 5'd10;
  localparam logic [4:0] SelAuipc = 5'd11;
  localparam logic [4:0] SelAddw  = 5'd12;
  localparam logic [4:0] SelSubw  = 5'd13;
  localparam logic [4:0] SelSllw  = 5'd14;
  localparam logic [4:0] SelSrlw  = 5'd15;
  localparam logic [4:0] SelSraw  = 5'd16;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;

  logic            dec_legal;
  logic [4:0]      dec_op;
  logic [5:0]      dec_sh;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;

  logic                  valid_q;
  logic                  enable_q;
  logic [SEL_SIZE-1:0]   sel_q;
  logic [SHIFT_SIZE-1:0] shift_q;
  logic [XLEN-1:0]       data_a_q;
  logic [XLEN-1:0]       data_b_q;
  logic [4:0]            rd_addr_q;
  logic                  rd_write_q;
  logic                  illegal_q;

  logic accept;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign imm_i  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
  // Upper immediate is presented unshifted; the ALU applies the <<12.
  assign imm_u  = {{(XLEN-20){1'b0}}, bus.instr[31:12]};

  assign bus.rs1_addr = bus.instr[19:15];
  assign bus.rs2_addr = bus.instr[24:20];
  assign bus.in_ready = !reset && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Combinational decode of the offered instruction into ALU op and raw operands.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = SelAdd;
    dec_sh    = '0;
    dec_a     = '0;
    dec_b     = '0;
    unique case (opcode)
      OpcOp: begin
        dec_a = bus.rs1_data;
        dec_b = bus.rs2_data;
        if (funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_op = SelAdd;
            3'b001:  begin dec_op = SelSll; dec_sh = bus.rs2_data[5:0]; end
            3'b010:  dec_op = SelSlt;
            3'b011:  dec_op = SelSltu;
            3'b100:  dec_op = SelXor;
            3'b101:  begin dec_op = SelSrl; dec_sh = bus.rs2_data[5:0]; end
            3'b110:  dec_op = SelOr;
            default: dec_op = SelAnd;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_op    = SelSub;
          end else if (funct3 == 3'b101) begin
            dec_legal = 1'b1;
            dec_op    = SelSra;
            dec_sh    = bus.rs2_data[5:0];
          end
        end
      end
      OpcOpImm: begin
        dec_a = bus.rs1_data;
        dec_b = imm_i;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_op = SelAdd;  end
          3'b010: begin dec_legal = 1'b1; dec_op = SelSlt;  end
          3'b011: begin dec_legal = 1'b1; dec_op = SelSltu; end
          3'b100: begin dec_legal = 1'b1; dec_op = SelXor;  end
          3'b110: begin dec_legal = 1'b1; dec_op = SelOr;   end
          3'b111: begin dec_legal = 1'b1; dec_op = SelAnd;  end
          3'b001: begin
            dec_legal = (bus.instr[31:26] == 6'b000000);
            dec_op    = SelSll;
            dec_sh    = bus.instr[25:20];
          end
          default: begin
            dec_legal = (bus.instr[31:26] == 6'b000000) || (bus.instr[31:26] == 6'b010000);
            dec_op    = bus.instr[30] ? SelSra : SelSrl;
            dec_sh    = bus.instr[25:20];
          end
        endcase
      end
      OpcOp32: begin
        dec_a = bus.rs1_data;
        dec_b = bus.rs2_data;
        dec_sh = {1'b0, bus.rs2_data[4:0]};
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin dec_legal = 1'b1; dec_op = SelAddw; end
            3'b001:  begin dec_legal = 1'b1; dec_op = SelSllw; end
            3'b101:  begin dec_legal = 1'b1; dec_op = SelSrlw; end
            default: dec_legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  begin dec_legal = 1'b1; dec_op = SelSubw; end
            3'b101:  begin dec_legal = 1'b1; dec_op = SelSraw; end
            default: dec_legal = 1'b0;
          endcase
        end
        if (dec_op == SelAddw || dec_op == SelSubw) dec_sh = '0;
      end
      OpcOpImm32: begin
        dec_a = bus.rs1_data;
        dec_b = imm_i;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_op = SelAddw; end
          3'b001: begin
            dec_legal = (funct7 == 7'b0000000);
            dec_op    = SelSllw;
            dec_sh    = {1'b0, bus.instr[24:20]};
          end
          3'b101: begin
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_op    = bus.instr[30] ? SelSraw : SelSrlw;
            dec_sh    = {1'b0, bus.instr[24:20]};
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OpcLui: begin
        dec_legal = 1'b1;
        dec_op    = SelLui;
        dec_a     = imm_u;
      end
      OpcAuipc: begin
        dec_legal = 1'b1;
        dec_op    = SelAuipc;
        dec_a     = imm_u;
        dec_b     = bus.pc;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Output register: reset > flush > accept > consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      enable_q   <= 1'b0;
      sel_q      <= '0;
      shift_q    <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      rd_addr_q  <= '0;
      rd_write_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      enable_q   <= 1'b0;
      rd_write_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      enable_q   <= dec_legal;
      sel_q      <= dec_legal ? SEL_SIZE'(dec_op) : '0;
      shift_q    <= dec_legal ? SHIFT_SIZE'(dec_sh) : '0;
      data_a_q   <= dec_legal ? dec_a : '0;
      data_b_q   <= dec_legal ? dec_b : '0;
      rd_addr_q  <= bus.instr[11:7];
      rd_write_q <= dec_legal && (bus.instr[11:7] != 5'd0);
      illegal_q  <= !dec_legal;
    end else if (valid_q && bus.out_ready) begin
      // Data fields keep their last value; only the side-effecting strobes drop.
      valid_q    <= 1'b0;
      enable_q   <= 1'b0;
      rd_write_q <= 1'b0;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.alu_enable    = enable_q;
  assign bus.alu_sel       = sel_q;
  assign bus.alu_shift_amt = shift_q;
  assign bus.alu_data_a    = data_a_q;
  assign bus.alu_data_b    = data_b_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.rd_write      = rd_write_q;
  assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_alu_issue_decoder.sv
// Bench for alu_issue_decoder: table-driven reference decode, cycle model and directed vectors.
module tb_alu_issue_decoder;
  logic clk;
  logic reset;
  logic flush;

  alu_issue_decoder_if #(.XLEN(64), .SEL_SIZE(5), .SHIFT_SIZE(6)) bus ();

  alu_issue_decoder #(.XLEN(64), .SEL_SIZE(5), .SHIFT_SIZE(6)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  sel;
    logic [5:0]  sh;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
  } ent_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_valid;
  logic m_known;
  ent_t m_e;

  // Reference decode: op number from lookup tables, operands chosen by instruction format.
  function automatic ent_t ref_decode(logic [31:0] i, logic [63:0] pc, logic [63:0] r1,
                                      logic [63:0] r2);
    int   r_tab[8] = '{0, 7, 2, 3, 6, 8, 5, 4};
    int   i_tab[8] = '{0, -1, 2, 3, 6, -1, 5, 4};
    int   s = -1;
    ent_t e;
    logic [6:0] opc = i[6:0];
    logic [2:0] f3  = i[14:12];
    logic [6:0] f7  = i[31:25];
    logic [63:0] sext = {{52{i[31]}}, i[31:20]};
    logic [63:0] upper = {44'd0, i[31:12]};
    if (opc == 7'h33) begin
      if (f7 == 7'h00) s = r_tab[f3];
      else if (f7 == 7'h20) s = (f3 == 3'd0) ? 1 : (f3 == 3'd5) ? 9 : -1;
    end else if (opc == 7'h13) begin
      s = i_tab[f3];
      if (f3 == 3'd1 && i[31:26] == 6'd0) s = 7;
      if (f3 == 3'd5) s = (i[31:26] == 6'd0) ? 8 : (i[31:26] == 6'd16) ? 9 : -1;
    end else if (opc == 7'h3B) begin
      if (f7 == 7'h00) s = (f3 == 3'd0) ? 12 : (f3 == 3'd1) ? 14 : (f3 == 3'd5) ? 15 : -1;
      else if (f7 == 7'h20) s = (f3 == 3'd0) ? 13 : (f3 == 3'd5) ? 16 : -1;
    end else if (opc == 7'h1B) begin
      if (f3 == 3'd0) s = 12;
      else if (f3 == 3'd1) s = (f7 == 7'h00) ? 14 : -1;
      else if (f3 == 3'd5) s = (f7 == 7'h00) ? 15 : (f7 == 7'h20) ? 16 : -1;
    end else if (opc == 7'h37) s = 10;
    else if (opc == 7'h17) s = 11;

    e.rd = i[11:7];
    if (s < 0) begin
      e.en = 1'b0; e.sel = '0; e.sh = '0; e.a = '0; e.b = '0; e.wr = 1'b0; e.ill = 1'b1;
      return e;
    end
    e.en  = 1'b1;
    e.ill = 1'b0;
    e.sel = 5'(s);
    e.wr  = (i[11:7] != 5'd0);
    e.sh  = '0;
    if (opc == 7'h37 || opc == 7'h17) begin
      e.a = upper;
      e.b = (opc == 7'h17) ? pc : 64'd0;
    end else begin
      e.a = r1;
      e.b = (opc == 7'h33 || opc == 7'h3B) ? r2 : sext;
    end
    if (s >= 7 && s <= 9) e.sh = (opc == 7'h33) ? r2[5:0] : i[25:20];
    if (s >= 14 && s <= 16) e.sh = {1'b0, (opc == 7'h3B) ? r2[4:0] : i[24:20]};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_update();
    logic acc;
    acc = bus.in_valid && !reset && (!m_valid || bus.out_ready);
    if (reset) begin
      m_valid = 1'b0;
      m_known = 1'b1;
      m_e = '{en: 1'b0, sel: '0, sh: '0, a: '0, b: '0, rd: '0, wr: 1'b0, ill: 1'b0};
    end else if (flush) begin
      m_valid = 1'b0; m_e.en = 1'b0; m_e.wr = 1'b0; m_known = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_known = 1'b1;
      m_e = ref_decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data);
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0; m_e.en = 1'b0; m_e.wr = 1'b0; m_known = 1'b0;
    end
  endtask

  task automatic model_compare();
    chk("in_ready", 64'(bus.in_ready), 64'(!reset && (!m_valid || bus.out_ready)));
    chk("rs1_addr", 64'(bus.rs1_addr), 64'(bus.instr[19:15]));
    chk("rs2_addr", 64'(bus.rs2_addr), 64'(bus.instr[24:20]));
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("alu_enable", 64'(bus.alu_enable), 64'(m_e.en));
    chk("rd_write", 64'(bus.rd_write), 64'(m_e.wr));
    if (m_known) begin
      chk("alu_sel", 64'(bus.alu_sel), 64'(m_e.sel));
      chk("alu_shift_amt", 64'(bus.alu_shift_amt), 64'(m_e.sh));
      chk("alu_data_a", bus.alu_data_a, m_e.a);
      chk("alu_data_b", bus.alu_data_b, m_e.b);
      chk("illegal", 64'(bus.illegal), 64'(m_e.ill));
      if (!m_e.ill) chk("rd_addr", 64'(bus.rd_addr), 64'(m_e.rd));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_compare();
  endtask

  task automatic offer(input logic [31:0] i, input logic [63:0] r1, input logic [63:0] r2,
                       input logic [63:0] p);
    bus.in_valid = 1'b1;
    bus.instr    = i;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    bus.pc       = p;
  endtask

  logic [31:0] extra_vec[10] = '{
    32'h40208133, 32'h002091B3, 32'h0020B1B3, 32'h0020F1B3, 32'h0020D1BB,
    32'h402081BB, 32'h0050959B, 32'h0000007F, 32'h402091B3, 32'h4050D59B
  };

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.pc        = '0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    m_valid = 1'b0;
    m_known = 1'b0;
    m_e = '{en: 1'b0, sel: '0, sh: '0, a: '0, b: '0, rd: '0, wr: 1'b0, ill: 1'b0};

    offer(32'h002081B3, 64'd1, 64'd2, 64'd0);
    cycle();
    cycle();
    chk("lit reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("lit reset in_ready", 64'(bus.in_ready), 64'd0);
    chk("lit reset data_a", bus.alu_data_a, 64'd0);
    reset = 1'b0;

    offer(32'h002081B3, 64'd5, 64'd7, 64'd0);
    cycle();
    chk("lit add sel", 64'(bus.alu_sel), 64'd0);
    chk("lit add a", bus.alu_data_a, 64'd5);
    chk("lit add b", bus.alu_data_b, 64'd7);
    chk("lit add rd", 64'(bus.rd_addr), 64'd3);
    chk("lit add rd_write", 64'(bus.rd_write), 64'd1);
    chk("lit add illegal", 64'(bus.illegal), 64'd0);

    offer(32'hFFF00093, 64'h1234, 64'd0, 64'd0);
    cycle();
    chk("lit addi b", bus.alu_data_b, 64'hFFFF_FFFF_FFFF_FFFF);
    offer(32'hFFF00013, 64'h1234, 64'd0, 64'd0);
    cycle();
    chk("lit addi x0 rd_write", 64'(bus.rd_write), 64'd0);
    chk("lit addi x0 enable", 64'(bus.alu_enable), 64'd1);

    offer(32'h43F35293, 64'h8000_0000_0000_0000, 64'd0, 64'd0);
    cycle();
    chk("lit srai sel", 64'(bus.alu_sel), 64'd9);
    chk("lit srai shamt", 64'(bus.alu_shift_amt), 64'd63);
    chk("lit srai rd", 64'(bus.rd_addr), 64'd5);
    offer(32'h43F3529B, 64'd3, 64'd0, 64'd0);
    cycle();
    chk("lit sraiw illegal", 64'(bus.illegal), 64'd1);
    chk("lit sraiw enable", 64'(bus.alu_enable), 64'd0);

    offer(32'h00001097, 64'd9, 64'd9, 64'h8000_0000);
    cycle();
    chk("lit auipc sel", 64'(bus.alu_sel), 64'd11);
    chk("lit auipc a", bus.alu_data_a, 64'd1);
    chk("lit auipc b", bus.alu_data_b, 64'h8000_0000);
    offer(32'h12345537, 64'd9, 64'd9, 64'h8000_0000);
    cycle();
    chk("lit lui sel", 64'(bus.alu_sel), 64'd10);
    chk("lit lui a", bus.alu_data_a, 64'h12345);
    chk("lit lui b", bus.alu_data_b, 64'd0);

    offer(32'h02208033, 64'd4, 64'd6, 64'd0);
    cycle();
    chk("lit mul illegal", 64'(bus.illegal), 64'd1);
    chk("lit mul enable", 64'(bus.alu_enable), 64'd0);
    chk("lit mul out_valid", 64'(bus.out_valid), 64'd1);

    for (int k = 0; k < 10; k++) begin
      offer(extra_vec[k], 64'h0123_4567_89AB_CDEF + 64'(k), 64'hFFFF_0000_0000_0025 + 64'(k),
            64'h1000 + 64'(4 * k));
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("lit consume enable", 64'(bus.alu_enable), 64'd0);

    // Backpressure: second entry must wait and then appear exactly once.
    bus.out_ready = 1'b0;
    offer(32'h002081B3, 64'd11, 64'd22, 64'd0);
    cycle();
    offer(32'h40208133, 64'd100, 64'd30, 64'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("lit stall in_ready", 64'(bus.in_ready), 64'd0);
      chk("lit stall a", bus.alu_data_a, 64'd11);
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("lit second sel", 64'(bus.alu_sel), 64'd1);
    chk("lit second a", bus.alu_data_a, 64'd100);
    bus.in_valid = 1'b0;
    cycle();
    chk("lit drained", 64'(bus.out_valid), 64'd0);

    // Flush during stall beats a simultaneous offer.
    bus.out_ready = 1'b0;
    offer(32'h002081B3, 64'd1, 64'd1, 64'd0);
    cycle();
    offer(32'h12345537, 64'd0, 64'd0, 64'd0);
    flush = 1'b1;
    cycle();
    chk("lit flush out_valid", 64'(bus.out_valid), 64'd0);
    chk("lit flush rd_write", 64'(bus.rd_write), 64'd0);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    chk("lit flush dropped", 64'(bus.out_valid), 64'd0);

    // Reset during stall clears everything.
    offer(32'h002081B3, 64'd5, 64'd7, 64'd0);
    cycle();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    cycle();
    chk("lit rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("lit rst a", bus.alu_data_a, 64'd0);
    chk("lit rst b", bus.alu_data_b, 64'd0);
    chk("lit rst rd", 64'(bus.rd_addr), 64'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_decoder.md
# alu_issue_decoder

Registered decode/issue stage that feeds the RV64 ALU. It accepts one 32-bit instruction per handshake, along with its PC and both register-file read values. It decodes the RV64I integer-compute subset (OP, OP-IMM, OP-32, OP-IMM-32, LUI, AUIPC) into ALU commands: `enable`, `sel`, `shift_amt`, operand A and operand B. It presents those commands, plus writeback control, through a one-entry valid/ready output register in front of the execute stage.

## Interface
- XLEN, 64, datapath width
- SEL_SIZE, 5, ALU select width; must be ≥5 because the 17 ops need 5 bits
- SHIFT_SIZE, 6, shift-amount width
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- flush  in  1  discard any held output entry
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- instr  in  32  instruction word
- pc  in  XLEN  address of instr
- rs1_addr  out  5  combinational, instr[19:15]
- rs2_addr  out  5  combinational, instr[24:20]
- rs1_data  in  XLEN  register value for rs1_addr, same cycle
- rs2_data  in  XLEN  register value for rs2_addr, same cycle
- out_valid  out  1  entry held
- out_ready  in  1  execute consumes entry
- alu_enable  out  1  ALU enable
- alu_sel  out  SEL_SIZE  op code: ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, OR=5, XOR=6, SLL=7, SRL=8, SRA=9, LUI=10, AUIPC=11, ADDW=12, SUBW=13, SLLW=14, SRLW=15, SRAW=16
- alu_shift_amt  out  SHIFT_SIZE  shift amount
- alu_data_a  out  XLEN  operand A
- alu_data_b  out  XLEN  operand B
- rd_addr  out  5  destination register
- rd_write  out  1  writeback enable
- illegal  out  1  entry is not a supported instruction

## Operation
- Accept occurs when in_valid && in_ready.
- in_ready = !reset && (!out_valid || out_ready). It is combinational.
- On accept, all outputs are loaded from the decode of instr, pc, rs1_data and rs2_data. Decode is combinational, then registered.

Decode rules:
- **OP (0110011).**
  - funct7=0000000: funct3 000→ADD, 001→SLL, 010→SLT, 011→SLTU, 100→XOR, 101→SRL, 110→OR, 111→AND.
  - funct7=0100000: 000→SUB, 101→SRA.
  - a=rs1_data, b=rs2_data, shift=rs2_data[5:0].
- **OP-IMM (0010011).**
  - funct3 000/010/011/100/110/111 → ADD/SLT/SLTU/XOR/OR/AND.
  - b = sign-extended instr[31:20] for all OP-IMM forms.
  - 001 → SLL only if instr[31:26]=000000.
  - 101 → SRL if instr[31:26]=000000; SRA if instr[31:26]=010000.
  - shift=instr[25:20]; a=rs1_data.
- **OP-32 (0111011).**
  - funct7=0000000: 000→ADDW, 001→SLLW, 101→SRLW.
  - funct7=0100000: 000→SUBW, 101→SRAW.
  - shift={0,rs2_data[4:0]}; a=rs1_data, b=rs2_data.
- **OP-IMM-32 (0011011).**
  - 000→ADDW with b = sign-extended instr[31:20].
  - 001→SLLW only if instr[31:25]=0.
  - 101→SRLW if instr[31:25]=0000000; SRAW if instr[31:25]=0100000.
  - shift={0,instr[24:20]}.
- **LUI (0110111).** sel=LUI, a = zero-extended instr[31:12], b=0, shift=0.
- **AUIPC (0010111).** sel=AUIPC, a = zero-extended instr[31:12], b=pc.
- **Unused fields.** shift=0 wherever the op does not use it.
- **Anything else is illegal**, including funct7=0000001 (M extension) and any unlisted opcode, funct3 or funct7. An illegal instruction is still accepted and presented with:
  - illegal=1, alu_enable=0, rd_write=0;
  - sel, shift, a and b all 0.
- **Legal instructions.** alu_enable=1, illegal=0, rd_addr=instr[11:7], rd_write=(rd_addr≠0).

## Timing
- Latency: an instruction accepted at edge N is presented with out_valid=1 from edge N to the next edge (one cycle).
- **Reset.** Synchronous, checked on each rising clk edge.
  - out_valid=0, alu_enable=0, rd_write=0, illegal=0.
  - alu_sel, alu_shift_amt, alu_data_a, alu_data_b, rd_addr all 0.
  - in_ready=0 while reset is high.
  - Reset mid-stall drops the held entry.
- **Stall.** While out_valid && !out_ready, every output is held bit-stable and in_ready=0.
- **Simultaneous consume and accept** (out_ready=1, in_valid=1): the register is reloaded. out_valid stays 1, giving back-to-back throughput of 1 per cycle with no bubble.
- **Consume without accept:** out_valid→0 at the next edge. Data outputs may hold their old values, but alu_enable and rd_write must go 0.
- **Flush.**
  - At the next edge: out_valid=0, alu_enable=0, rd_write=0.
  - Flush has priority over a simultaneous accept; the offered instruction is dropped.
  - in_ready is unaffected by flush.
- Priority order: reset > flush > accept > consume.

## Test plan
- ADD x3,x1,x2: instr=0x002081B3, rs1_data=5, rs2_data=7 → next cycle sel=0, a=5, b=7, rd_addr=3, rd_write=1, illegal=0.
- ADDI x1,x0,-1: instr=0xFFF00093 → sel=0, b=0xFFFF_FFFF_FFFF_FFFF. A variant with rd=x0 (0xFFF00013) → rd_write=0, alu_enable=1.
- SRAI x5,x6,63: instr=0x43F35293 → sel=9, shift_amt=63, rd_addr=5. Then SRAIW with shamt field 0x3F → illegal=1.
- AUIPC x1,1: instr=0x00001097, pc=0x8000_0000 → sel=11, a=0x1, b=0x8000_0000. LUI x10,0x12345 (0x12345537) → sel=10, a=0x12345, b=0.
- Backpressure: two back-to-back instructions with out_ready=0 for 3 cycles.
  - First entry is held stable and in_ready=0 throughout.
  - Second entry appears in the cycle after out_ready rises.
  - No loss or duplication.
- Illegal/flush: MUL 0x02208033 → illegal=1, alu_enable=0, out_valid=1. Flush during a stall → out_valid=0 next edge. Reset during a stall → all outputs 0.
